// File: rtl/udc_pkg.sv
// Shared constants and the wrap/saturate mode type for the up/down counter.
// The optional compare feature of updown_counter_mod is enabled with macro UDC_CMP_EN.
package udc_pkg;

   localparam logic UDC_UP = 1'b1;
   localparam logic UDC_DN = 1'b0;

   typedef enum logic {
      UDC_WRAP = 1'b0,
      UDC_SAT  = 1'b1
   } udc_mode_e;

   function automatic udc_mode_e udc_mode(input int saturate);
      return (saturate != 0) ? UDC_SAT : UDC_WRAP;
   endfunction

endpackage

// File: rtl/udc_next_count.sv
// Combinational next-state logic for the up/down counter: load clamp, step,
// wrap/saturate at the ends, end events and the cascade terminal count.
module udc_next_count
   import udc_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MOD_MAX  = 2**WIDTH-1,
   parameter int SATURATE = 0
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up_dn,
   input  logic             en,
   input  logic             ld,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] next_count,
   output logic             tc,
   output logic             ovf_evt,
   output logic             unf_evt
);

   localparam logic [WIDTH-1:0] MAX_V  = MOD_MAX[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam udc_mode_e        MODE   = udc_mode(SATURATE);

   function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] value);
      return (value > MAX_V) ? MAX_V : value;
   endfunction

   logic at_top_s;
   logic at_bot_s;

   assign at_top_s = (count == MAX_V);
   assign at_bot_s = (count == ZERO_V);

   // Next count and end events; load outranks counting.
   always_comb begin
      next_count = count;
      ovf_evt    = 1'b0;
      unf_evt    = 1'b0;
      if (ld) begin
         next_count = clamp(data_in);
      end else if (en) begin
         if (up_dn == UDC_UP) begin
            ovf_evt = at_top_s;
            if (!at_top_s) begin
               next_count = count + ONE_V;
            end else begin
               case (MODE)
                  UDC_SAT:  next_count = MAX_V;
                  UDC_WRAP: next_count = ZERO_V;
                  default:  next_count = ZERO_V;
               endcase
            end
         end else begin
            unf_evt = at_bot_s;
            if (!at_bot_s) begin
               next_count = count - ONE_V;
            end else begin
               case (MODE)
                  UDC_SAT:  next_count = ZERO_V;
                  UDC_WRAP: next_count = MAX_V;
                  default:  next_count = MAX_V;
               endcase
            end
         end
      end else begin
         next_count = count;
      end
   end

   assign tc = ovf_evt | unf_evt;

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with load, modulus, wrap/saturate and sticky flags.
// Define UDC_CMP_EN to add the cmp_val input and registered cmp_hit output.
module updown_counter_mod
   import udc_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MOD_MAX  = 2**WIDTH-1,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             ld,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] data_in,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf,
   output logic             unf
`ifdef UDC_CMP_EN
   ,
   input  logic [WIDTH-1:0] cmp_val,
   output logic             cmp_hit
`endif
);

   function automatic logic sticky_next(input logic flag, input logic evt, input logic clr);
      return evt ? 1'b1 : (clr ? 1'b0 : flag);
   endfunction

   logic [WIDTH-1:0] count_r;
   logic             ovf_r;
   logic             unf_r;
   logic [WIDTH-1:0] next_count_s;
   logic             tc_s;
   logic             ovf_evt_s;
   logic             unf_evt_s;

   udc_next_count #(
      .WIDTH    (WIDTH),
      .MOD_MAX  (MOD_MAX),
      .SATURATE (SATURATE)
   ) u_next (
      .count      (count_r),
      .up_dn      (up_dn),
      .en         (en),
      .ld         (ld),
      .data_in    (data_in),
      .next_count (next_count_s),
      .tc         (tc_s),
      .ovf_evt    (ovf_evt_s),
      .unf_evt    (unf_evt_s)
   );

   // Count and sticky flag registers; a set event outranks clr_flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {WIDTH{1'b0}};
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else begin
         count_r <= next_count_s;
         ovf_r   <= sticky_next(ovf_r, ovf_evt_s, clr_flags);
         unf_r   <= sticky_next(unf_r, unf_evt_s, clr_flags);
      end
   end

   assign count = count_r;
   assign ovf   = ovf_r;
   assign unf   = unf_r;
   assign tc    = tc_s;

`ifdef UDC_CMP_EN
   logic cmp_hit_r;

   // Period-match strobe, one cycle after the count equals cmp_val.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmp_hit_r <= 1'b0;
      end else begin
         cmp_hit_r <= (count_r == cmp_val);
      end
   end

   assign cmp_hit = cmp_hit_r;
`endif

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench: wrap and saturate counters (WIDTH=4, MOD_MAX=9) against
// an arithmetic model, plus a two-digit BCD cascade chained through tc.
module tb_updown_counter_mod;

   localparam int W  = 4;
   localparam int MX = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, en, ld, up_dn, clr_flags, casc_en;
   logic [W-1:0] data_in;
   logic [W-1:0] cnt_w, cnt_s, cnt_lo, cnt_hi;
   logic         tc_w, ovf_w, unf_w, tc_s, ovf_s, unf_s;
   logic         tc_lo, ovf_lo, unf_lo, tc_hi, ovf_hi, unf_hi;
`ifdef UDC_CMP_EN
   logic [W-1:0] cmp_val;
   logic         hit_w, hit_s, hit_lo, hit_hi;
`endif

   int errors = 0;
   int checks = 0;

   updown_counter_mod #(.WIDTH(W), .MOD_MAX(MX), .SATURATE(0)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .ld(ld), .up_dn(up_dn), .data_in(data_in),
      .clr_flags(clr_flags), .count(cnt_w), .tc(tc_w), .ovf(ovf_w), .unf(unf_w)
`ifdef UDC_CMP_EN
      , .cmp_val(cmp_val), .cmp_hit(hit_w)
`endif
   );

   updown_counter_mod #(.WIDTH(W), .MOD_MAX(MX), .SATURATE(1)) u_sat (
      .clk(clk), .reset(reset), .en(en), .ld(ld), .up_dn(up_dn), .data_in(data_in),
      .clr_flags(clr_flags), .count(cnt_s), .tc(tc_s), .ovf(ovf_s), .unf(unf_s)
`ifdef UDC_CMP_EN
      , .cmp_val(cmp_val), .cmp_hit(hit_s)
`endif
   );

   updown_counter_mod #(.WIDTH(W), .MOD_MAX(MX), .SATURATE(0)) u_lo (
      .clk(clk), .reset(reset), .en(casc_en), .ld(1'b0), .up_dn(1'b1), .data_in(4'd0),
      .clr_flags(1'b0), .count(cnt_lo), .tc(tc_lo), .ovf(ovf_lo), .unf(unf_lo)
`ifdef UDC_CMP_EN
      , .cmp_val(cmp_val), .cmp_hit(hit_lo)
`endif
   );

   updown_counter_mod #(.WIDTH(W), .MOD_MAX(MX), .SATURATE(0)) u_hi (
      .clk(clk), .reset(reset), .en(tc_lo), .ld(1'b0), .up_dn(1'b1), .data_in(4'd0),
      .clr_flags(1'b0), .count(cnt_hi), .tc(tc_hi), .ovf(ovf_hi), .unf(unf_hi)
`ifdef UDC_CMP_EN
      , .cmp_val(cmp_val), .cmp_hit(hit_hi)
`endif
   );

   // ---------------- reference model ----------------
   function automatic int model_next(int c, bit l, bit e, bit up, int d, bit sat);
      if (l) return (d > MX) ? MX : d;
      if (!e) return c;
      if (up) return sat ? ((c + 1 > MX) ? MX : c + 1) : (c + 1) % (MX + 1);
      return sat ? ((c - 1 < 0) ? 0 : c - 1) : (c + MX) % (MX + 1);
   endfunction

   function automatic bit model_tc(int c, bit e, bit l, bit up);
      return e && !l && ((up && c == MX) || (!up && c == 0));
   endfunction

   function automatic bit model_flag(bit f, bit evt, bit clr);
      if (evt) return 1'b1;
      return clr ? 1'b0 : f;
   endfunction

   int m_cw, m_cs, m_casc;
   bit m_ow, m_uw, m_os, m_us, m_valid = 1'b0;
`ifdef UDC_CMP_EN
   bit m_hit;
`endif

   always @(posedge clk) begin
      if (reset) begin
         m_cw <= 0; m_cs <= 0; m_casc <= 0;
         m_ow <= 1'b0; m_uw <= 1'b0; m_os <= 1'b0; m_us <= 1'b0;
         m_valid <= 1'b1;
`ifdef UDC_CMP_EN
         m_hit <= 1'b0;
`endif
      end else begin
         m_cw <= model_next(m_cw, ld, en, up_dn, int'(data_in), 1'b0);
         m_cs <= model_next(m_cs, ld, en, up_dn, int'(data_in), 1'b1);
         m_ow <= model_flag(m_ow, model_tc(m_cw, en, ld, up_dn) && up_dn, clr_flags);
         m_uw <= model_flag(m_uw, model_tc(m_cw, en, ld, up_dn) && !up_dn, clr_flags);
         m_os <= model_flag(m_os, model_tc(m_cs, en, ld, up_dn) && up_dn, clr_flags);
         m_us <= model_flag(m_us, model_tc(m_cs, en, ld, up_dn) && !up_dn, clr_flags);
         if (casc_en) m_casc <= (m_casc + 1) % 100;
`ifdef UDC_CMP_EN
         m_hit <= (m_cw == int'(cmp_val));
`endif
      end
   end

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model count wrap", int'(cnt_w), m_cw);
         chk("model tc wrap", int'(tc_w), int'(model_tc(m_cw, en, ld, up_dn)));
         chk("model ovf wrap", int'(ovf_w), int'(m_ow));
         chk("model unf wrap", int'(unf_w), int'(m_uw));
         chk("model count sat", int'(cnt_s), m_cs);
         chk("model tc sat", int'(tc_s), int'(model_tc(m_cs, en, ld, up_dn)));
         chk("model ovf sat", int'(ovf_s), int'(m_os));
         chk("model unf sat", int'(unf_s), int'(m_us));
         chk("model bcd cascade", int'(cnt_hi) * 10 + int'(cnt_lo), m_casc);
`ifdef UDC_CMP_EN
         chk("model cmp_hit", int'(hit_w), int'(m_hit));
`endif
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(bit l, bit e, bit up, int d, bit clr);
      ld = l; en = e; up_dn = up; data_in = W'(d); clr_flags = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; casc_en = 1'b0;
`ifdef UDC_CMP_EN
      cmp_val = 4'd5;
`endif
      drive(1'b1, 1'b1, 1'b1, 7, 1'b0);
      tick(); tick();
      chk("reset count", int'(cnt_w), 0);
      chk("reset ovf", int'(ovf_w), 0);
      chk("reset unf", int'(unf_w), 0);
      reset = 1'b0;

      // load 7, count up through the top
      drive(1'b1, 1'b0, 1'b1, 7, 1'b0); tick();
      chk("load 7", int'(cnt_w), 7);
      drive(1'b0, 1'b1, 1'b1, 0, 1'b0); tick();
      chk("up to 8", int'(cnt_w), 8);
      tick();
      chk("up to 9", int'(cnt_w), 9);
      chk("tc at 9", int'(tc_w), 1);
      chk("ovf before wrap", int'(ovf_w), 0);
      tick();
      chk("wrap to 0", int'(cnt_w), 0);
      chk("ovf after wrap", int'(ovf_w), 1);
      chk("sat holds 9", int'(cnt_s), 9);

      // en=0 holds while up_dn toggles
      drive(1'b0, 1'b0, 1'b0, 0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b1, 0, 1'b0); tick();
      chk("hold with en=0", int'(cnt_w), 0);

      // load 1, count down through zero, then clear flags
      drive(1'b1, 1'b0, 1'b1, 1, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 0, 1'b0); tick();
      chk("down to 0", int'(cnt_w), 0);
      chk("tc at 0 down", int'(tc_w), 1);
      tick();
      chk("wrap to 9", int'(cnt_w), 9);
      chk("unf set", int'(unf_w), 1);
      drive(1'b0, 1'b0, 1'b0, 0, 1'b1); tick();
      chk("unf cleared", int'(unf_w), 0);
      chk("ovf cleared", int'(ovf_w), 0);

      // saturate: up at top holds, then down at 0 with clear on the same edge
      drive(1'b1, 1'b0, 1'b1, 9, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b1, 0, 1'b0); tick(); tick();
      chk("sat stays 9", int'(cnt_s), 9);
      chk("sat ovf", int'(ovf_s), 1);
      drive(1'b1, 1'b0, 1'b1, 0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 0, 1'b1); tick();
      chk("sat stays 0", int'(cnt_s), 0);
      chk("sat unf wins clear", int'(unf_s), 1);
      chk("sat ovf cleared", int'(ovf_s), 0);
      chk("wrap down to 9", int'(cnt_w), 9);

      // clamp, load priority, mid-count reset
      drive(1'b1, 1'b0, 1'b1, 14, 1'b0); tick();
      chk("clamp 14", int'(cnt_w), 9);
      drive(1'b1, 1'b1, 1'b1, 3, 1'b0);
      chk("tc masked by ld", int'(tc_w), 0);
      tick();
      chk("load beats en", int'(cnt_w), 3);
      drive(1'b0, 1'b1, 1'b1, 0, 1'b0); tick();
      chk("up to 4", int'(cnt_w), 4);
      reset = 1'b1; tick();
      chk("mid reset count", int'(cnt_w), 0);
      chk("mid reset unf", int'(unf_w), 0);
      reset = 1'b0;

`ifdef UDC_CMP_EN
      // compare strobe one cycle after count==5
      drive(1'b1, 1'b0, 1'b1, 0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b1, 0, 1'b0);
      repeat (5) tick();
      chk("count at 5", int'(cnt_w), 5);
      chk("no hit yet", int'(hit_w), 0);
      tick();
      chk("cmp_hit", int'(hit_w), 1);
      tick();
      chk("cmp_hit drops", int'(hit_w), 0);
`endif

      // BCD cascade 00..99 -> 00
      drive(1'b0, 1'b0, 1'b1, 0, 1'b0);
      casc_en = 1'b1;
      repeat (57) tick();
      chk("bcd lo 57", int'(cnt_lo), 7);
      chk("bcd hi 57", int'(cnt_hi), 5);
      repeat (42) tick();
      chk("bcd 99 lo", int'(cnt_lo), 9);
      chk("bcd 99 hi", int'(cnt_hi), 9);
      tick();
      chk("bcd roll lo", int'(cnt_lo), 0);
      chk("bcd roll hi", int'(cnt_hi), 0);
      casc_en = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
